// File: rtl/prbs8_checker.sv
// Receive-side checker for the 8-bit XNOR LFSR pattern stream: self-synchronises on the
// incoming words, declares lock, then counts word and bit errors while locked.
module prbs8_checker #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [7:0]       data_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] word_err_cnt_o,
    output logic [CNT_W-1:0] bit_err_cnt_o
);

    typedef enum logic [1:0] {
        StHunt   = 2'b00,
        StVerify = 2'b01,
        StLocked = 2'b10
    } state_e;

    localparam logic [3:0]       LockCnt = 4'(LOCK_CNT);
    localparam logic [3:0]       LossCnt = 4'(LOSS_CNT);
    localparam logic [CNT_W-1:0] CntMax  = '1;

    function automatic logic [7:0] next_word(input logic [7:0] w);
        return {w[6:0], ~(w[7] ^ w[5] ^ w[4] ^ w[3])};
    endfunction

    state_e           state_q, state_d;
    logic [7:0]       pred_q, pred_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    logic [7:0]       diff;
    logic             mism;
    logic [3:0]       pop;
    logic [CNT_W:0]   bit_sum;

    always_comb begin
        state_d    = state_q;
        pred_d     = pred_q;
        match_d    = match_q;
        miss_d     = miss_q;
        err_d      = 1'b0;
        word_cnt_d = word_cnt_q;
        bit_cnt_d  = bit_cnt_q;

        diff = data_i ^ pred_q;
        mism = |diff;
        pop  = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + 4'(diff[i]);
        end
        // One extra bit so the overflow can be detected and clamped.
        bit_sum = {1'b0, bit_cnt_q} + (CNT_W+1)'(pop);

        if (en_i) begin
            unique case (state_q)
                StHunt: begin
                    // 0xFF is the generator's lock-up word; never seed from it.
                    if (data_i != 8'hFF) begin
                        pred_d  = next_word(data_i);
                        match_d = '0;
                        state_d = StVerify;
                    end
                end
                StVerify: begin
                    if (!mism) begin
                        match_d = match_q + 4'd1;
                        pred_d  = next_word(pred_q);
                        if (match_q + 4'd1 == LockCnt) begin
                            state_d = StLocked;
                            miss_d  = '0;
                        end
                    end else if (data_i == 8'hFF) begin
                        state_d = StHunt;
                    end else begin
                        pred_d  = next_word(data_i);
                        match_d = '0;
                    end
                end
                StLocked: begin
                    // Flywheel: received words never reseed the predictor once locked.
                    pred_d = next_word(pred_q);
                    if (mism) begin
                        err_d      = 1'b1;
                        miss_d     = miss_q + 4'd1;
                        word_cnt_d = (word_cnt_q == CntMax) ? word_cnt_q : word_cnt_q + CNT_W'(1);
                        bit_cnt_d  = bit_sum[CNT_W] ? CntMax : bit_sum[CNT_W-1:0];
                        if (miss_q + 4'd1 == LossCnt) begin
                            state_d = StHunt;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = StHunt;
            endcase
        end

        if (clr_i) begin
            word_cnt_d = '0;
            bit_cnt_d  = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StHunt;
            pred_q     <= 8'h00;
            match_q    <= '0;
            miss_q     <= '0;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pred_q     <= pred_d;
            match_q    <= match_d;
            miss_q     <= miss_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign state_o        = state_q;
    assign locked_o       = (state_q == StLocked);
    assign err_o          = err_q;
    assign word_err_cnt_o = word_cnt_q;
    assign bit_err_cnt_o  = bit_cnt_q;

endmodule

// File: tb/tb_prbs8_checker.sv
// Bench for prbs8_checker: a default instance and a narrow-counter instance, each checked
// every cycle against a scoreboard fed by a behavioural model, plus directed spot checks.
module tb_prbs8_checker;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, clr_a = 1'b0;
    logic [7:0]  data_a = 8'h00;
    logic        locked_a, err_a;
    logic [1:0]  state_a;
    logic [15:0] werr_a, berr_a;

    logic        rst_b = 1'b1, en_b = 1'b0, clr_b = 1'b0;
    logic [7:0]  data_b = 8'h00;
    logic        locked_b, err_b;
    logic [1:0]  state_b;
    logic [3:0]  werr_b, berr_b;

    prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut_a (
        .clk_i(clk), .rst_i(rst_a), .en_i(en_a), .data_i(data_a), .clr_i(clr_a),
        .locked_o(locked_a), .err_o(err_a), .state_o(state_a),
        .word_err_cnt_o(werr_a), .bit_err_cnt_o(berr_a)
    );

    prbs8_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .en_i(en_b), .data_i(data_b), .clr_i(clr_b),
        .locked_o(locked_b), .err_o(err_b), .state_o(state_b),
        .word_err_cnt_o(werr_b), .bit_err_cnt_o(berr_b)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        lk;
        logic        er;
        logic [15:0] we;
        logic [15:0] be;
    } obs_t;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    bit   sel      = 1'b0;

    // Behavioural reference state.
    int         m_lock = 4, m_loss = 3, m_max = 65535;
    logic [1:0] m_state = 2'd0;
    logic [7:0] m_pred  = 8'h00;
    int         m_match = 0, m_miss = 0, m_werr = 0, m_berr = 0;
    logic       m_err   = 1'b0;

    function automatic logic [7:0] nxt(input logic [7:0] w);
        logic fb;
        fb = ~(w[7] ^ w[5] ^ w[4] ^ w[3]);
        return {w[6:0], fb};
    endfunction

    task automatic model(input logic rst, input logic en, input logic [7:0] d, input logic clr);
        if (rst) begin
            m_state = 2'd0; m_pred = 8'h00; m_match = 0; m_miss = 0;
            m_werr = 0; m_berr = 0; m_err = 1'b0;
            return;
        end
        m_err = 1'b0;
        if (en) begin
            case (m_state)
                2'd0: if (d != 8'hFF) begin
                    m_pred = nxt(d); m_match = 0; m_state = 2'd1;
                end
                2'd1: if (d == m_pred) begin
                    m_match++;
                    m_pred = nxt(m_pred);
                    if (m_match == m_lock) begin m_state = 2'd2; m_miss = 0; end
                end else if (d == 8'hFF) begin
                    m_state = 2'd0;
                end else begin
                    m_pred = nxt(d); m_match = 0;
                end
                default: begin
                    if (d != m_pred) begin
                        m_err  = 1'b1;
                        m_miss++;
                        m_werr = (m_werr + 1 > m_max) ? m_max : m_werr + 1;
                        m_berr = m_berr + $countones(d ^ m_pred);
                        if (m_berr > m_max) m_berr = m_max;
                        if (m_miss == m_loss) m_state = 2'd0;
                    end else begin
                        m_miss = 0;
                    end
                    m_pred = nxt(m_pred);
                end
            endcase
        end
        if (clr) begin m_werr = 0; m_berr = 0; end
    endtask

    function automatic obs_t sample();
        obs_t o;
        if (sel) o = '{st: state_b, lk: locked_b, er: err_b, we: 16'(werr_b), be: 16'(berr_b)};
        else     o = '{st: state_a, lk: locked_a, er: err_a, we: werr_a, be: berr_a};
        return o;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, and compare registered outputs #1 after the edge.
    task automatic step(input logic rst, input logic en, input logic [7:0] d, input logic clr);
        obs_t e, g;
        if (sel) begin rst_b = rst; en_b = en; data_b = d; clr_b = clr; end
        else     begin rst_a = rst; en_a = en; data_a = d; clr_a = clr; end
        @(posedge clk);
        model(rst, en, d, clr);
        sb.push_back('{st: m_state, lk: (m_state == 2'd2), er: m_err,
                       we: 16'(m_werr), be: 16'(m_berr)});
        #1;
        g = sample();
        e = sb.pop_front();
        check("state_o", 16'(g.st), 16'(e.st));
        check("locked_o", 16'(g.lk), 16'(e.lk));
        check("err_o", 16'(g.er), 16'(e.er));
        check("word_err_cnt", g.we, e.we);
        check("bit_err_cnt", g.be, e.be);
    endtask

    obs_t cur;
    logic [7:0] seq0 [5] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F};
    logic [7:0] seq1 [7] = '{8'hFF, 8'hFF, 8'h07, 8'h0F, 8'h1E, 8'h3D, 8'h7A};

    initial begin
        // Instance A: LOCK_CNT=4, LOSS_CNT=3, CNT_W=16.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b1, 8'h5A, 1'b1);
        cur = sample();
        check("reset_state", 16'(cur.st), 16'd0);
        check("reset_locked", 16'(cur.lk), 16'd0);

        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, seq0[i], 1'b0);
            cur = sample();
            if (i == 0) check("verify_after_00", 16'(cur.st), 16'd1);
        end
        check("locked_after_0F", 16'(cur.lk), 16'd1);
        check("counters_zero_at_lock", cur.we | cur.be, 16'd0);

        step(1'b0, 1'b1, 8'h1F, 1'b0);
        cur = sample();
        check("err_pulse_1F", 16'(cur.er), 16'd1);
        step(1'b0, 1'b1, 8'h3D, 1'b0);
        step(1'b0, 1'b1, 8'h7A, 1'b0);
        cur = sample();
        check("single_werr", cur.we, 16'd1);
        check("single_berr", cur.be, 16'd1);
        check("flywheel_lock", 16'(cur.lk), 16'd1);
        check("next_pred_F4", 16'(m_pred), 16'h00F4);

        step(1'b0, 1'b1, m_pred, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0);
        cur = sample();
        check("loss_werr", cur.we, 16'd3);
        check("loss_berr", cur.be, 16'd24);
        check("loss_to_hunt", 16'(cur.st), 16'd0);

        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, seq1[i], 1'b0);
            cur = sample();
            if (i == 1) check("ff_stays_hunt", 16'(cur.st), 16'd0);
            if (i == 2) check("verify_after_07", 16'(cur.st), 16'd1);
        end
        check("relock_after_7A", 16'(cur.lk), 16'd1);

        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) step(1'b0, 1'b1, m_pred, 1'b0);
            else            step(1'b0, 1'b0, 8'hA5, 1'b0);
        end
        cur = sample();
        check("gapped_lock", 16'(cur.lk), 16'd1);
        check("gapped_no_err", cur.we, 16'd3);
        step(1'b1, 1'b1, m_pred ^ 8'hFF, 1'b0);
        cur = sample();
        check("midlock_reset", {cur.st, cur.lk, cur.er, 12'd0} | cur.we | cur.be, 16'd0);

        // Instance B: LOCK_CNT=4, LOSS_CNT=15, CNT_W=4.
        rst_a = 1'b1; en_a = 1'b0;
        sel = 1'b1; m_loss = 15; m_max = 15;
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, seq0[i], 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0);
        step(1'b0, 1'b1, m_pred, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b0);
        cur = sample();
        check("sat_werr", cur.we, 16'd15);
        check("sat_berr", cur.be, 16'd15);
        check("sat_still_locked", 16'(cur.lk), 16'd1);
        step(1'b0, 1'b1, m_pred ^ 8'hFF, 1'b1);
        cur = sample();
        check("clr_werr", cur.we, 16'd0);
        check("clr_berr", cur.be, 16'd0);
        check("clr_err_pulse", 16'(cur.er), 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
